// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the 4x4 keypad scanner.
// Optional build macro: KEYPAD_GHOST_REJECT_EN.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } keypad_state_t;

   // Indexed by {row, col}
   localparam logic [3:0] KEYMAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   function automatic logic [1:0] lowest_row(
      input logic [NUM_ROWS-1:0] p
   );
      lowest_row = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--)
         if (p[i]) lowest_row = 2'(i);
   endfunction

endpackage

// File: rtl/keypad_scan_controller_sync.sv
// Two-flop synchronizer for asynchronous keypad row pins.
// Resets to all-ones so released (pulled-up) rows read idle.
module row_synchronizer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad column scanner with press/release debounce.
// Define KEYPAD_GHOST_REJECT_EN to reject multi-row samples.
module keypad_scan_controller
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 4096,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] rows,
   output logic [NUM_COLS-1:0] cols,
   output logic [3:0]          key_code,
   output logic                key_valid,
   output logic                key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   keypad_state_t state, state_nx;

   logic [NUM_ROWS-1:0] rows_s;
   logic [NUM_ROWS-1:0] pressed;
   logic [1:0]          col_idx;
   logic [1:0]          lrow;
   logic [DW-1:0]       dwell;
   logic [CW-1:0]       cnt;

   logic dwell_end, cnt_end;
   logic hit, lat_pressed, abort;
   logic adv_col, latch, accept, rel_done;

   row_synchronizer #(.WIDTH(NUM_ROWS)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rows_s)
   );

   assign pressed     = ~rows_s;
   assign lat_pressed = pressed[lrow];
   assign dwell_end   = (dwell == DW'(SCAN_DIV - 1));
   assign cnt_end     = (cnt == CW'(DEBOUNCE_CYCLES - 1));

`ifdef KEYPAD_GHOST_REJECT_EN
   logic [NUM_ROWS-1:0] others;
   logic                multi;
   assign multi  = (pressed & (pressed - 1'b1)) != '0;
   assign hit    = (pressed != '0) && !multi;
   assign others = pressed & ~(NUM_ROWS'(1) << lrow);
   assign abort  = (others != '0);
`else
   assign hit    = (pressed != '0);
   assign abort  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= SCAN;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      adv_col  = 1'b0;
      latch    = 1'b0;
      accept   = 1'b0;
      rel_done = 1'b0;
      unique case (state)
         SCAN: begin
            if (dwell_end) begin
               if (hit) begin
                  latch    = 1'b1;
                  state_nx = DEBOUNCE;
               end else begin
                  adv_col  = 1'b1;
               end
            end
         end
         DEBOUNCE: begin
            if (!lat_pressed || abort) begin
               adv_col  = 1'b1;
               state_nx = SCAN;
            end else if (cnt_end) begin
               accept   = 1'b1;
               state_nx = HELD;
            end
         end
         HELD: begin
            if (!lat_pressed) state_nx = RELEASE;
         end
         RELEASE: begin
            if (lat_pressed) begin
               state_nx = HELD;
            end else if (cnt_end) begin
               rel_done = 1'b1;
               adv_col  = 1'b1;
               state_nx = SCAN;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   // Counters restart on every state change
   always_ff @(posedge clk) begin
      if (!reset) begin
         col_idx   <= 2'd0;
         lrow      <= 2'd0;
         dwell     <= '0;
         cnt       <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= accept;
         if (state != SCAN || dwell_end)
            dwell <= '0;
         else
            dwell <= dwell + DW'(1);
         if (state_nx != state || state == SCAN
             || state == HELD)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (adv_col) col_idx <= col_idx + 2'd1;
         if (latch)   lrow    <= lowest_row(pressed);
         if (accept) begin
            key_code <= KEYMAP[{lrow, col_idx}];
            key_held <= 1'b1;
         end
         if (rel_done) key_held <= 1'b0;
      end
   end

   always_comb begin
      cols = ~(NUM_COLS'(1) << col_idx);
   end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Self-checking bench for keypad_scan_controller.
// Honours KEYPAD_GHOST_REJECT_EN when defined.
module tb_keypad_scan_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   keypad_scan_controller #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Physical keypad: press[r][c] shorts row r to column c
   logic [3:0] press [4];

   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         if ((press[r] & ~cols) != 4'h0) rows[r] = 1'b0;
   end

   typedef struct {
      logic [1:0] row;
      logic [1:0] col;
      logic [3:0] code;
   } vec_t;

   vec_t       tbl [16];
   logic [3:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         seen   = 0;

   task automatic release_all();
      for (int r = 0; r < 4; r++) press[r] = 4'h0;
   endtask

   task automatic check4(
      input string n, input logic [3:0] got,
      input logic [3:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b", n, got, exp);
      end
   endtask

   task automatic check1(
      input string n, input logic got, input logic exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b", n, got, exp);
      end
   endtask

   // One clock; every key_valid pulse is scored here
   task automatic tick();
      logic [3:0] e;
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) begin
         seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid code=%h expected none",
                     key_code);
         end else begin
            e = exp_q.pop_front();
            if (key_code !== e) begin
               errors++;
               $display("FAIL key_code got=%h expected=%h",
                        key_code, e);
            end
         end
      end
   endtask

   task automatic wait_event(input string n, input int bound);
      int s0;
      s0 = seen;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (seen != s0) break;
      end
      checks++;
      if (seen == s0) begin
         errors++;
         $display("FAIL %s timeout got=none expected=event", n);
      end
   endtask

   task automatic wait_unheld(input string n, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (key_held === 1'b0) break;
         tick();
      end
      check1(n, key_held, 1'b0);
   endtask

   task automatic wait_cols(
      input string n, input logic [3:0] c, input int bound
   );
      for (int i = 0; i < bound; i++) begin
         if (cols === c) break;
         tick();
      end
      check4(n, cols, c);
   endtask

   initial begin
      tbl = '{
         '{2'd0, 2'd0, 4'h1}, '{2'd0, 2'd1, 4'h2},
         '{2'd0, 2'd2, 4'h3}, '{2'd0, 2'd3, 4'hA},
         '{2'd1, 2'd0, 4'h4}, '{2'd1, 2'd1, 4'h5},
         '{2'd1, 2'd2, 4'h6}, '{2'd1, 2'd3, 4'hB},
         '{2'd2, 2'd0, 4'h7}, '{2'd2, 2'd1, 4'h8},
         '{2'd2, 2'd2, 4'h9}, '{2'd2, 2'd3, 4'hC},
         '{2'd3, 2'd0, 4'hE}, '{2'd3, 2'd1, 4'h0},
         '{2'd3, 2'd2, 4'hF}, '{2'd3, 2'd3, 4'hD}
      };
      release_all();
      reset = 1'b0;
      repeat (3) tick();
      check4("rst_cols", cols, 4'b1110);
      check4("rst_code", key_code, 4'h0);
      check1("rst_valid", key_valid, 1'b0);
      check1("rst_held", key_held, 1'b0);
      reset = 1'b1;

      // Idle scan: 4 cycles per column, wrapping
      for (int i = 0; i < 40; i++) begin
         logic [3:0] c;
         c = ~(4'b0001 << ((i / 4) % 4));
         check4("idle_cols", cols, c);
         tick();
      end

      // Row1/col2: single event, columns frozen while held
      press[1][2] = 1'b1;
      exp_q.push_back(4'h6);
      wait_event("ev_6", 80);
      tick();
      check1("pulse_once", key_valid, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      check1("held_6", key_held, 1'b1);
      check4("frozen_6", cols, 4'b1011);
      release_all();
      wait_unheld("unheld_6", 40);
      check4("resume_6", cols, 4'b0111);

      // Short press row3/col1: no event, scan resumes at col2
      wait_cols("sync_c1", 4'b1101, 40);
      press[3][1] = 1'b1;
      repeat (5) tick();
      check4("short_frozen", cols, 4'b1101);
      release_all();
      for (int i = 0; i < 20; i++) begin
         if (cols !== 4'b1101) break;
         tick();
      end
      check4("short_resume", cols, 4'b1011);
      check1("short_held", key_held, 1'b0);

      // Bouncy release: no second event
      press[1][2] = 1'b1;
      exp_q.push_back(4'h6);
      wait_event("ev_bounce", 80);
      release_all();
      repeat (3) tick();
      press[1][2] = 1'b1;
      repeat (2) tick();
      release_all();
      repeat (5) tick();
      check1("bounce_held", key_held, 1'b1);
      wait_unheld("bounce_unheld", 30);

      // Rows 0 and 2 low in column 0
      press[0][0] = 1'b1;
      press[2][0] = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
      begin
         int s0;
         s0 = seen;
         repeat (60) tick();
         check1("ghost_none", seen != s0, 1'b0);
         check1("ghost_held", key_held, 1'b0);
      end
      release_all();
`else
      exp_q.push_back(4'h1);
      wait_event("ev_multi", 80);
      check1("multi_held", key_held, 1'b1);
      release_all();
      wait_unheld("multi_unheld", 40);
`endif

      // Key map table
      foreach (tbl[k]) begin
         logic [3:0] fc, nc;
         fc = ~(4'b0001 << tbl[k].col);
         nc = ~(4'b0001 << (tbl[k].col + 2'd1));
         press[tbl[k].row][tbl[k].col] = 1'b1;
         exp_q.push_back(tbl[k].code);
         wait_event("ev_tbl", 80);
         check1("tbl_held", key_held, 1'b1);
         check4("tbl_frozen", cols, fc);
         release_all();
         wait_unheld("tbl_unheld", 40);
         check4("tbl_next", cols, nc);
      end

      // Reset while HELD
      press[2][3] = 1'b1;
      exp_q.push_back(4'hC);
      wait_event("ev_rst", 80);
      check1("rst_pre_held", key_held, 1'b1);
      reset = 1'b0;
      release_all();
      tick();
      check4("hrst_cols", cols, 4'b1110);
      check1("hrst_held", key_held, 1'b0);
      check4("hrst_code", key_code, 4'h0);
      check1("hrst_valid", key_valid, 1'b0);
      reset = 1'b1;
      repeat (20) tick();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending got=%0d expected=0",
                  exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
